// File: rtl/verificador_pkg.sv
// Shared types and constants for the memory-game play checker.
// FIM_TIMEOUT exists only when JOGADA_TIMEOUT_EN is defined.
package verificador_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    ESPERA      = 4'd2,
    REGISTRA    = 4'd4,
    COMPARA     = 4'd5,
    PROXIMA     = 4'd6,
    SOLTA       = 4'd7,
    FIM_ACERTO  = 4'd10,
`ifdef JOGADA_TIMEOUT_EN
    FIM_TIMEOUT = 4'd13,
`endif
    FIM_ERRO    = 4'd14
  } estado_t;

  localparam logic [3:0] SEQ_JOGADAS [0:15] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000,
    4'b0100, 4'b0010, 4'b0001, 4'b0001,
    4'b0010, 4'b0010, 4'b0100, 4'b0100,
    4'b1000, 4'b1000, 4'b0001, 4'b0100
  };

  function automatic logic [3:0] jogada_esperada(input logic [3:0] endereco);
    return SEQ_JOGADAS[endereco];
  endfunction

endpackage

// File: rtl/verificador_jogadas_if.sv
// Player/game signal bundle; the game circuit is the master, the checker the slave.
// db_timeout is present only when JOGADA_TIMEOUT_EN is defined.
interface verificador_jogadas_if;
  logic       iniciar;
  logic [3:0] chaves;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic [3:0] leds;
  logic       db_jogada_valida;
  logic       db_igual;
  logic [3:0] db_endereco;
  logic [3:0] db_estado;
`ifdef JOGADA_TIMEOUT_EN
  logic       db_timeout;
`endif

  modport master (
    output iniciar, chaves,
    input  pronto, acertou, errou, leds,
           db_jogada_valida, db_igual, db_endereco, db_estado
`ifdef JOGADA_TIMEOUT_EN
         , db_timeout
`endif
  );

  modport slave (
    input  iniciar, chaves,
    output pronto, acertou, errou, leds,
           db_jogada_valida, db_igual, db_endereco, db_estado
`ifdef JOGADA_TIMEOUT_EN
         , db_timeout
`endif
  );
endinterface

// File: rtl/filtro_chaves.sv
// Switch debouncer: pulses estavel_o once chaves_i has been nonzero and unchanged
// for HOLD_CICLOS consecutive cycles while enabled.
module filtro_chaves #(
  parameter int unsigned HOLD_CICLOS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita_i,
  input  logic [3:0] chaves_i,
  output logic       estavel_o
);

  localparam int unsigned     CNT_W = $clog2(HOLD_CICLOS + 1);
  localparam logic [CNT_W-1:0] ALVO = CNT_W'(HOLD_CICLOS);

  logic [3:0]       anterior_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturate at the target so a held value cannot wrap while the FSM reacts.
  always_comb begin
    cnt_d = '0;
    if (habilita_i && (chaves_i != 4'b0000) && (chaves_i == anterior_q)) begin
      cnt_d = (cnt_q == ALVO) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      anterior_q <= 4'b0000;
      cnt_q      <= '0;
    end else begin
      anterior_q <= chaves_i;
      cnt_q      <= cnt_d;
    end
  end

  assign estavel_o = habilita_i && (cnt_q == ALVO);

endmodule

// File: rtl/verificador_jogadas.sv
// Memory-game play checker: debounces plays, compares them with SEQ_JOGADAS, reports the result.
// Optional JOGADA_TIMEOUT_EN adds a wait timeout, FIM_TIMEOUT state and db_timeout.
module verificador_jogadas
  import verificador_pkg::*;
#(
  parameter int unsigned N_JOGADAS   = 16,
  parameter int unsigned HOLD_CICLOS = 2
`ifdef JOGADA_TIMEOUT_EN
, parameter int unsigned TIMEOUT_CICLOS = 3000
`endif
) (
  input logic                  clock,
  input logic                  reset,
  verificador_jogadas_if.slave bus
);

  localparam logic [3:0] ULTIMO = 4'(N_JOGADAS - 1);

  estado_t    estado_q, estado_d;
  logic [3:0] endereco_q, endereco_d;
  logic [3:0] jogada_q, jogada_d;
  logic       estavel;
  logic       igual;

  filtro_chaves #(
    .HOLD_CICLOS(HOLD_CICLOS)
  ) u_filtro (
    .clock      (clock),
    .reset      (reset),
    .habilita_i (estado_q == ESPERA),
    .chaves_i   (bus.chaves),
    .estavel_o  (estavel)
  );

  assign igual = (jogada_q == jogada_esperada(endereco_q));

`ifdef JOGADA_TIMEOUT_EN
  localparam int unsigned TMR_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;

  logic [TMR_W-1:0] tmr_q;
  logic             esgotou;

  // ESPERA and SOLTA are never adjacent, so clearing outside them equals clearing on entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmr_q <= '0;
    end else if ((estado_q == ESPERA) || (estado_q == SOLTA)) begin
      tmr_q <= tmr_q + TMR_W'(1);
    end else begin
      tmr_q <= '0;
    end
  end

  assign esgotou        = (tmr_q == TMR_W'(TIMEOUT_CICLOS - 1));
  assign bus.db_timeout = (estado_q == FIM_TIMEOUT);
`endif

  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    jogada_d   = jogada_q;
    case (estado_q)
      INICIAL: if (bus.iniciar) estado_d = PREPARA;
      PREPARA: begin
        endereco_d = 4'd0;
        jogada_d   = 4'b0000;
        estado_d   = ESPERA;
      end
      ESPERA: begin
        if (estavel) estado_d = REGISTRA;
`ifdef JOGADA_TIMEOUT_EN
        else if (esgotou) estado_d = FIM_TIMEOUT;
`endif
      end
      REGISTRA: begin
        jogada_d = bus.chaves;
        estado_d = COMPARA;
      end
      COMPARA: begin
        if (!igual)                    estado_d = FIM_ERRO;
        else if (endereco_q == ULTIMO) estado_d = FIM_ACERTO;
        else                           estado_d = SOLTA;
      end
      SOLTA: begin
        if (bus.chaves == 4'b0000) estado_d = PROXIMA;
`ifdef JOGADA_TIMEOUT_EN
        else if (esgotou) estado_d = FIM_TIMEOUT;
`endif
      end
      PROXIMA: begin
        if (endereco_q != ULTIMO) endereco_d = endereco_q + 4'd1;
        estado_d = ESPERA;
      end
      FIM_ACERTO, FIM_ERRO: if (bus.iniciar) estado_d = PREPARA;
`ifdef JOGADA_TIMEOUT_EN
      FIM_TIMEOUT: if (bus.iniciar) estado_d = PREPARA;
`endif
      default: estado_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= INICIAL;
      endereco_q <= 4'd0;
      jogada_q   <= 4'b0000;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      jogada_q   <= jogada_d;
    end
  end

  assign bus.pronto           = (estado_q == FIM_ACERTO) || (estado_q == FIM_ERRO)
`ifdef JOGADA_TIMEOUT_EN
                              || (estado_q == FIM_TIMEOUT)
`endif
                              ;
  assign bus.acertou          = (estado_q == FIM_ACERTO);
  assign bus.errou            = (estado_q == FIM_ERRO)
`ifdef JOGADA_TIMEOUT_EN
                              || (estado_q == FIM_TIMEOUT)
`endif
                              ;
  assign bus.leds             = jogada_q;
  assign bus.db_jogada_valida = (estado_q == REGISTRA);
  assign bus.db_igual         = igual;
  assign bus.db_endereco      = endereco_q;
  assign bus.db_estado        = estado_q;

endmodule

// File: tb/tb_verificador_jogadas.sv
// Directed bench for verificador_jogadas with a scoreboard of registered plays.
// Define JOGADA_TIMEOUT_EN to also exercise the timeout path.
module tb_verificador_jogadas;

  logic clock;
  logic reset;

  verificador_jogadas_if bus ();

  verificador_jogadas #(
    .N_JOGADAS   (16),
    .HOLD_CICLOS (2)
`ifdef JOGADA_TIMEOUT_EN
  , .TIMEOUT_CICLOS (50)
`endif
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] jogada;
    logic [3:0] endereco;
  } esperado_t;

  esperado_t  fila [$];
  logic [3:0] seq [0:15] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000,
    4'b0100, 4'b0010, 4'b0001, 4'b0001,
    4'b0010, 4'b0010, 4'b0100, 4'b0100,
    4'b1000, 4'b1000, 4'b0001, 4'b0100
  };

  int passed = 0;
  int total  = 0;
  int pulsos = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive one play for 10 cycles, then release for 10 cycles.
  task automatic applyStimulus(input logic [3:0] jogada, input logic [3:0] endereco);
    fila.push_back('{jogada: jogada, endereco: endereco});
    bus.chaves = jogada;
    tick(10);
    bus.chaves = 4'b0000;
    tick(10);
  endtask

  // Registered play lands in leds one cycle after the db_jogada_valida pulse.
  initial begin
    logic      pendente;
    esperado_t e;
    pendente = 1'b0;
    forever begin
      @(negedge clock);
      if (pendente) begin
        if (fila.size() == 0) begin
          checkOutput("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          e = fila.pop_front();
          checkOutput("sb_leds", 32'(bus.leds), 32'(e.jogada));
          checkOutput("sb_endereco", 32'(bus.db_endereco), 32'(e.endereco));
        end
      end
      pendente = bus.db_jogada_valida;
      if (bus.db_jogada_valida) pulsos++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p0;
    reset       = 1'b1;
    bus.iniciar = 1'b0;
    bus.chaves  = 4'b0000;
    tick(1);
    reset = 1'b0;
    checkOutput("rst_estado", 32'(bus.db_estado), 32'd0);
    checkOutput("rst_endereco", 32'(bus.db_endereco), 32'd0);
    checkOutput("rst_pronto", 32'(bus.pronto), 32'd0);
    checkOutput("rst_acertou", 32'(bus.acertou), 32'd0);
    checkOutput("rst_errou", 32'(bus.errou), 32'd0);
    checkOutput("rst_leds", 32'(bus.leds), 32'd0);
    checkOutput("rst_valida", 32'(bus.db_jogada_valida), 32'd0);
    tick(10);

    $display("[TB] start: iniciar held 5 cycles");
    bus.iniciar = 1'b1;
    tick(1);
    checkOutput("start_prepara", 32'(bus.db_estado), 32'd1);
    tick(1);
    checkOutput("start_espera", 32'(bus.db_estado), 32'd2);
    checkOutput("start_endereco", 32'(bus.db_endereco), 32'd0);
    tick(3);
    checkOutput("start_hold_espera", 32'(bus.db_estado), 32'd2);
    checkOutput("start_pronto", 32'(bus.pronto), 32'd0);
    bus.iniciar = 1'b0;

    $display("[TB] full correct round");
    p0 = pulsos;
    for (int i = 0; i < 16; i++) applyStimulus(seq[i], 4'(i));
    checkOutput("ok_pulsos", 32'(pulsos - p0), 32'd16);
    checkOutput("ok_estado", 32'(bus.db_estado), 32'd10);
    checkOutput("ok_acertou", 32'(bus.acertou), 32'd1);
    checkOutput("ok_pronto", 32'(bus.pronto), 32'd1);
    checkOutput("ok_errou", 32'(bus.errou), 32'd0);
    checkOutput("ok_leds", 32'(bus.leds), 32'b0100);
    checkOutput("ok_endereco", 32'(bus.db_endereco), 32'd15);
    checkOutput("ok_igual", 32'(bus.db_igual), 32'd1);

    $display("[TB] restart from FIM_ACERTO, wrong 5th play");
    bus.iniciar = 1'b1;
    tick(1);
    bus.iniciar = 1'b0;
    tick(1);
    checkOutput("re_estado", 32'(bus.db_estado), 32'd2);
    checkOutput("re_endereco", 32'(bus.db_endereco), 32'd0);
    checkOutput("re_pronto", 32'(bus.pronto), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(seq[i], 4'(i));
    applyStimulus(4'b1000, 4'd4);
    checkOutput("err_estado", 32'(bus.db_estado), 32'd14);
    checkOutput("err_errou", 32'(bus.errou), 32'd1);
    checkOutput("err_pronto", 32'(bus.pronto), 32'd1);
    checkOutput("err_acertou", 32'(bus.acertou), 32'd0);
    checkOutput("err_endereco", 32'(bus.db_endereco), 32'd4);
    checkOutput("err_igual", 32'(bus.db_igual), 32'd0);

    $display("[TB] glitch then multi-bit play");
    bus.iniciar = 1'b1;
    tick(1);
    bus.iniciar = 1'b0;
    tick(1);
    p0 = pulsos;
    bus.chaves = 4'b0001;
    tick(1);
    bus.chaves = 4'b0000;
    tick(10);
    checkOutput("glitch_pulsos", 32'(pulsos - p0), 32'd0);
    checkOutput("glitch_estado", 32'(bus.db_estado), 32'd2);
    fila.push_back('{jogada: 4'b0011, endereco: 4'd0});
    bus.chaves = 4'b0011;
    tick(10);
    bus.chaves = 4'b0000;
    checkOutput("multi_estado", 32'(bus.db_estado), 32'd14);
    checkOutput("multi_errou", 32'(bus.errou), 32'd1);
    checkOutput("multi_leds", 32'(bus.leds), 32'b0011);

    $display("[TB] reset during SOLTA at play 7");
    bus.iniciar = 1'b1;
    tick(1);
    bus.iniciar = 1'b0;
    tick(1);
    for (int i = 0; i < 6; i++) applyStimulus(seq[i], 4'(i));
    fila.push_back('{jogada: seq[6], endereco: 4'd6});
    bus.chaves = seq[6];
    tick(10);
    checkOutput("solta_estado", 32'(bus.db_estado), 32'd7);
    checkOutput("solta_endereco", 32'(bus.db_endereco), 32'd6);
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_estado", 32'(bus.db_estado), 32'd0);
    checkOutput("arst_endereco", 32'(bus.db_endereco), 32'd0);
    checkOutput("arst_leds", 32'(bus.leds), 32'd0);
    checkOutput("arst_pronto", 32'(bus.pronto), 32'd0);
    bus.chaves = 4'b0000;
    tick(1);
    reset = 1'b0;
    tick(1);
    checkOutput("arst_idle", 32'(bus.db_estado), 32'd0);

`ifdef JOGADA_TIMEOUT_EN
    $display("[TB] timeout in ESPERA");
    bus.iniciar = 1'b1;
    tick(1);
    bus.iniciar = 1'b0;
    tick(1);
    tick(49);
    checkOutput("to_before", 32'(bus.db_estado), 32'd2);
    tick(1);
    checkOutput("to_estado", 32'(bus.db_estado), 32'd13);
    checkOutput("to_errou", 32'(bus.errou), 32'd1);
    checkOutput("to_pronto", 32'(bus.pronto), 32'd1);
    checkOutput("to_flag", 32'(bus.db_timeout), 32'd1);
`endif

    checkOutput("sb_vazio", 32'(fila.size()), 32'd0);
    checkOutput("pulsos_total", 32'(pulsos), 32'd29);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
